led_key_ctrl: RTL and testbench

Wishbone classic slave that owns the DE10-Standard LEDs, slide switches and push keys, replacing the free-running heartbeat top-level logic. Firmware writes LED patterns, selects heartbeat or register LED drive, reads synchronized switches and debounced keys, and gets a sticky key-press interrupt. Sits on the CPU I/O bus beside the SDRAM and VGA slaves.

---
 rtl/led_key_ctrl.sv | 151 +++++++++++++++
 tb/tb_led_key_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_key_ctrl.sv
// Wishbone classic slave for the board LEDs, slide switches and push keys.
// Provides LED/heartbeat drive, synchronized switches, debounced keys and a sticky key-press IRQ.
module led_key_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TICK_MSB        = 30
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [1:0]  adr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    output logic        ack_o,
    input  logic [9:0]  sw_i,
    input  logic [3:0]  key_i,
    output logic [9:0]  led_o,
    output logic        irq_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ADR_LED    = 2'd0,
        ADR_CTRL   = 2'd1,
        ADR_STATUS = 2'd2,
        ADR_KEYEVT = 2'd3
    } adr_e;

    logic [9:0]        r_led;
    logic              r_mode;
    logic              r_irqen;
    logic [3:0]        r_keyevt;
    logic [TICK_MSB:0] r_tick;
    logic [9:0]        r_sw_meta;
    logic [9:0]        r_sw_sync;
    logic [3:0]        r_key_meta;
    logic [3:0]        r_key_sync;
    logic [3:0]        r_key_db;
    logic [CW-1:0]     r_db_cnt [4];

    logic              w_req;
    logic              w_wr;
    logic [31:0]       w_rdata;
    logic [3:0]        w_clr;
    logic [3:0]        w_press;
    logic              w_unused;

    // A held strobe is only accepted while ack_o is low, so acks never come back to back.
    assign w_req    = cyc_i & stb_i & ~ack_o;
    assign w_wr     = w_req & we_i;
    assign w_clr    = (w_wr && adr_e'(adr_i) == ADR_KEYEVT && sel_i[0]) ? dat_i[3:0] : 4'b0000;
    assign w_unused = &{1'b0, dat_i[31:10], sel_i[3:2]};

    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    always_comb begin
        w_rdata = '0;
        case (adr_e'(adr_i))
            ADR_LED:    w_rdata[9:0] = r_led;
            ADR_CTRL:   w_rdata[1:0] = {r_irqen, r_mode};
            ADR_STATUS: begin
                w_rdata[9:0]   = r_sw_sync;
                w_rdata[19:16] = ~r_key_db;
            end
            ADR_KEYEVT: w_rdata[3:0] = r_keyevt;
            default:    w_rdata = '0;
        endcase
    end

    // A press is the debounced state accepting a synchronized low while it was released.
    always_comb begin
        w_press = '0;
        for (int n = 0; n < 4; n++) begin
            w_press[n] = r_key_db[n] & ~r_key_sync[n] & (r_db_cnt[n] == CNT_LAST);
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_o   <= 1'b0;
            dat_o   <= '0;
            r_led   <= '0;
            r_mode  <= 1'b0;
            r_irqen <= 1'b0;
        end else begin
            ack_o <= w_req;
            dat_o <= w_req ? w_rdata : '0;
            if (w_wr) begin
                case (adr_e'(adr_i))
                    ADR_LED: begin
                        if (sel_i[0]) r_led[7:0] <= dat_i[7:0];
                        if (sel_i[1]) r_led[9:8] <= dat_i[9:8];
                    end
                    ADR_CTRL: begin
                        if (sel_i[0]) {r_irqen, r_mode} <= dat_i[1:0];
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_keyevt <= '0;
            irq_o    <= 1'b0;
            r_tick   <= '0;
            led_o    <= '0;
        end else begin
            // A press arriving on the clear edge survives the clear.
            r_keyevt <= (r_keyevt & ~w_clr) | w_press;
            irq_o    <= r_irqen & (|r_keyevt);
            r_tick   <= r_tick + {{TICK_MSB{1'b0}}, 1'b1};
            led_o    <= r_mode ? r_tick[TICK_MSB -: 10] : r_led;
        end
    end

    // NOTE: the debounce counters are ordinary flops, not a RAM, so they are reset with everything else.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sw_meta  <= '0;
            r_sw_sync  <= '0;
            r_key_meta <= '1;
            r_key_sync <= '1;
            r_key_db   <= '1;
            for (int n = 0; n < 4; n++) begin
                r_db_cnt[n] <= '0;
            end
        end else begin
            r_sw_meta  <= sw_i;
            r_sw_sync  <= r_sw_meta;
            r_key_meta <= key_i;
            r_key_sync <= r_key_meta;
            for (int n = 0; n < 4; n++) begin
                if (r_key_sync[n] == r_key_db[n]) begin
                    r_db_cnt[n] <= '0;
                end else if (r_db_cnt[n] == CNT_LAST) begin
                    r_key_db[n] <= r_key_sync[n];
                    r_db_cnt[n] <= '0;
                end else begin
                    r_db_cnt[n] <= r_db_cnt[n] + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_led_key_ctrl.sv
// Self-checking bench for led_key_ctrl: register vectors, heartbeat wrap, debounce and IRQ
// corner cases, and randomized LED/switch traffic against a small reference model.
module tb_led_key_ctrl;

    localparam int DEB = 8;
    localparam int TMSB = 10;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cyc_i;
    logic        stb_i;
    logic        we_i;
    logic [1:0]  adr_i;
    logic [3:0]  sel_i;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        ack_o;
    logic [9:0]  sw_i;
    logic [3:0]  key_i;
    logic [9:0]  led_o;
    logic        irq_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] n_edges;
    logic [31:0] rd;

    typedef struct {
        logic        we;
        logic [1:0]  adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic [31:0] exp_rd;
        logic [9:0]  exp_led;
    } vec_t;

    vec_t vecs[17];

    led_key_ctrl #(.DEBOUNCE_CYCLES(DEB), .TICK_MSB(TMSB)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
        .adr_i(adr_i), .sel_i(sel_i), .dat_i(dat_i), .dat_o(dat_o), .ack_o(ack_o),
        .sw_i(sw_i), .key_i(key_i), .led_o(led_o), .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    // Rising edges since the last reset release; the heartbeat tick equals this count mod 2^(TMSB+1).
    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) n_edges <= 0;
        else       n_edges <= n_edges + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wb(input logic we, input logic [1:0] adr, input logic [3:0] sel,
                      input logic [31:0] dat, output logic [31:0] rdata);
        int waited;
        @(negedge clk_i);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; sel_i = sel; dat_i = dat;
        waited = 0;
        do begin
            @(negedge clk_i);
            waited++;
        end while (!ack_o && waited < 8);
        check("ack_latency", 32'(waited), 32'd1);
        rdata = dat_o;
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    endtask

    function automatic logic [9:0] hb_expect(input logic [31:0] n);
        logic [31:0] t;
        t = (n - 32'd1) % 32'd2048;
        return t[10:1];
    endfunction

    function automatic logic [31:0] status_expect(input logic [9:0] sw, input logic [3:0] pressed);
        return {12'd0, pressed, 6'd0, sw};
    endfunction

    task automatic hold_key_low(input int k, input int cycles);
        @(negedge clk_i);
        key_i[k] = 1'b0;
        repeat (cycles) @(negedge clk_i);
        key_i[k] = 1'b1;
    endtask

    initial begin
        logic [9:0]  led_m;
        logic [9:0]  sw_m;
        logic [9:0]  mask;
        logic [31:0] d;
        logic [3:0]  s;
        bit          found;

        vecs[0]  = '{1'b1, 2'd0, 4'hF, 32'h0000_02A5, 32'h0,         10'h2A5};
        vecs[1]  = '{1'b0, 2'd0, 4'hF, 32'h0,         32'h0000_02A5, 10'h2A5};
        vecs[2]  = '{1'b1, 2'd0, 4'h1, 32'h0000_03FF, 32'h0,         10'h2FF};
        vecs[3]  = '{1'b0, 2'd0, 4'hF, 32'h0,         32'h0000_02FF, 10'h2FF};
        vecs[4]  = '{1'b1, 2'd0, 4'h2, 32'hFFFF_FC00, 32'h0,         10'h0FF};
        vecs[5]  = '{1'b0, 2'd0, 4'hF, 32'h0,         32'h0000_00FF, 10'h0FF};
        vecs[6]  = '{1'b1, 2'd1, 4'hF, 32'hFFFF_FFFC, 32'h0,         10'h0FF};
        vecs[7]  = '{1'b0, 2'd1, 4'hF, 32'h0,         32'h0,         10'h0FF};
        vecs[8]  = '{1'b1, 2'd1, 4'h0, 32'h0000_0003, 32'h0,         10'h0FF};
        vecs[9]  = '{1'b0, 2'd1, 4'hF, 32'h0,         32'h0,         10'h0FF};
        vecs[10] = '{1'b1, 2'd2, 4'hF, 32'hFFFF_FFFF, 32'h0,         10'h0FF};
        vecs[11] = '{1'b0, 2'd2, 4'hF, 32'h0,         32'h0,         10'h0FF};
        vecs[12] = '{1'b0, 2'd3, 4'hF, 32'h0,         32'h0,         10'h0FF};
        vecs[13] = '{1'b1, 2'd0, 4'hF, 32'hFFFF_FFFF, 32'h0,         10'h3FF};
        vecs[14] = '{1'b0, 2'd0, 4'hF, 32'h0,         32'h0000_03FF, 10'h3FF};
        vecs[15] = '{1'b1, 2'd0, 4'h0, 32'h0,         32'h0,         10'h3FF};
        vecs[16] = '{1'b0, 2'd0, 4'hF, 32'h0,         32'h0000_03FF, 10'h3FF};

        rst_i = 1'b1; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        adr_i = '0; sel_i = '0; dat_i = '0; sw_i = '0; key_i = 4'hF;
        repeat (3) @(negedge clk_i);
        check("reset_led", {22'd0, led_o}, 32'd0);
        check("reset_ack", {31'd0, ack_o}, 32'd0);
        check("reset_irq", {31'd0, irq_o}, 32'd0);
        check("reset_dat", dat_o, 32'd0);
        rst_i = 1'b0;
        wb(1'b0, 2'd1, 4'hF, 32'h0, rd);
        check("reset_ctrl_read", rd, 32'd0);

        for (int i = 0; i < 17; i++) begin
            wb(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat, rd);
            if (!vecs[i].we) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            @(negedge clk_i);
            check($sformatf("vec%0d_led", i), {22'd0, led_o}, {22'd0, vecs[i].exp_led});
        end

        // Held strobe: ack and data every other cycle.
        @(negedge clk_i);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 2'd0; sel_i = 4'hF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            check($sformatf("held_ack%0d", i), {31'd0, ack_o}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("held_dat%0d", i), dat_o, (i % 2 == 0) ? 32'h3FF : 32'h0);
        end
        cyc_i = 1'b0; stb_i = 1'b0;

        // Heartbeat mode, including the counter wrap.
        wb(1'b1, 2'd1, 4'hF, 32'h1, rd);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check("heartbeat_led", {22'd0, led_o}, {22'd0, hb_expect(n_edges)});
        end
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(negedge clk_i);
            if (n_edges % 2048 == 0) found = 1'b1;
        end
        check("heartbeat_wrap_seen", {31'd0, found}, 32'd1);
        check("heartbeat_max", {22'd0, led_o}, 32'h3FF);
        @(negedge clk_i);
        check("heartbeat_wrapped", {22'd0, led_o}, 32'h0);
        wb(1'b1, 2'd1, 4'hF, 32'h0, rd);
        @(negedge clk_i);
        check("back_to_reg_led", {22'd0, led_o}, 32'h3FF);

        // Switch synchronizer latency and read-only STATUS.
        @(negedge clk_i);
        sw_i = 10'h155;
        @(posedge clk_i);
        @(posedge clk_i);
        wb(1'b0, 2'd2, 4'hF, 32'h0, rd);
        check("status_sw", rd, status_expect(10'h155, 4'h0));
        wb(1'b1, 2'd2, 4'hF, 32'hFFFF_FFFF, rd);
        wb(1'b0, 2'd2, 4'hF, 32'h0, rd);
        check("status_ro", rd, status_expect(10'h155, 4'h0));

        // Glitches shorter than the debounce window are ignored.
        hold_key_low(2, 5);
        repeat (12) @(negedge clk_i);
        hold_key_low(2, DEB - 1);
        repeat (12) @(negedge clk_i);
        wb(1'b0, 2'd2, 4'hF, 32'h0, rd);
        check("glitch_status", rd, status_expect(10'h155, 4'h0));
        wb(1'b0, 2'd3, 4'hF, 32'h0, rd);
        check("glitch_keyevt", rd, 32'h0);

        @(negedge clk_i);
        key_i[2] = 1'b0;
        repeat (15) @(negedge clk_i);
        wb(1'b0, 2'd2, 4'hF, 32'h0, rd);
        check("press_status", rd, status_expect(10'h155, 4'h4));
        key_i[2] = 1'b1;
        repeat (15) @(negedge clk_i);
        wb(1'b0, 2'd2, 4'hF, 32'h0, rd);
        check("release_status", rd, status_expect(10'h155, 4'h0));
        wb(1'b0, 2'd3, 4'hF, 32'h0, rd);
        check("press_keyevt", rd, 32'h4);
        check("irq_disabled", {31'd0, irq_o}, 32'd0);
        wb(1'b1, 2'd1, 4'hF, 32'h2, rd);
        check("irq_enable_lag", {31'd0, irq_o}, 32'd0);
        @(negedge clk_i);
        check("irq_enabled", {31'd0, irq_o}, 32'd1);

        // Key 0 press completes on the same edge that clears flags 0 and 2.
        @(negedge clk_i);
        key_i[0] = 1'b0;
        repeat (DEB + 1) @(posedge clk_i);
        wb(1'b1, 2'd3, 4'hF, 32'h5, rd);
        check("same_edge_irq", {31'd0, irq_o}, 32'd1);
        wb(1'b0, 2'd3, 4'hF, 32'h0, rd);
        check("same_edge_keyevt", rd, 32'h1);
        check("same_edge_irq_hold", {31'd0, irq_o}, 32'd1);
        wb(1'b1, 2'd3, 4'hF, 32'h1, rd);
        check("w1c_irq_lag", {31'd0, irq_o}, 32'd1);
        @(negedge clk_i);
        check("w1c_irq_drop", {31'd0, irq_o}, 32'd0);
        wb(1'b0, 2'd3, 4'hF, 32'h0, rd);
        check("w1c_keyevt", rd, 32'h0);
        key_i[0] = 1'b1;
        repeat (15) @(negedge clk_i);
        wb(1'b0, 2'd3, 4'hF, 32'h0, rd);
        check("release_no_event", rd, 32'h0);

        // Randomized LED writes/reads and switch changes against the reference model.
        led_m = 10'h3FF;
        sw_m  = 10'h155;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0: begin
                    d = $urandom;
                    s = 4'($urandom);
                    mask = {{2{s[1]}}, {8{s[0]}}};
                    led_m = (led_m & ~mask) | (d[9:0] & mask);
                    wb(1'b1, 2'd0, s, d, rd);
                    @(negedge clk_i);
                    check("rand_led_out", {22'd0, led_o}, {22'd0, led_m});
                end
                1: begin
                    wb(1'b0, 2'd0, 4'($urandom), 32'h0, rd);
                    check("rand_led_read", rd, {22'd0, led_m});
                end
                default: begin
                    @(negedge clk_i);
                    sw_m = 10'($urandom);
                    sw_i = sw_m;
                    @(posedge clk_i);
                    @(posedge clk_i);
                    wb(1'b0, 2'd2, 4'hF, 32'h0, rd);
                    check("rand_status", rd, status_expect(sw_m, 4'h0));
                end
            endcase
        end

        // Reset in the middle of a transaction with the IRQ asserted.
        hold_key_low(1, 15);
        repeat (15) @(negedge clk_i);
        check("pre_reset_irq", {31'd0, irq_o}, 32'd1);
        wb(1'b1, 2'd0, 4'hF, 32'h0000_0155, rd);
        @(negedge clk_i);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 2'd0; sel_i = 4'hF;
        @(posedge clk_i);
        #1;
        check("pre_reset_ack", {31'd0, ack_o}, 32'd1);
        rst_i = 1'b1;
        #1;
        check("midreset_ack", {31'd0, ack_o}, 32'd0);
        check("midreset_led", {22'd0, led_o}, 32'd0);
        check("midreset_irq", {31'd0, irq_o}, 32'd0);
        check("midreset_dat", dat_o, 32'd0);
        @(negedge clk_i);
        cyc_i = 1'b0; stb_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        wb(1'b0, 2'd0, 4'hF, 32'h0, rd);
        check("post_reset_led_reg", rd, 32'h0);
        wb(1'b0, 2'd1, 4'hF, 32'h0, rd);
        check("post_reset_ctrl", rd, 32'h0);
        wb(1'b0, 2'd3, 4'hF, 32'h0, rd);
        check("post_reset_keyevt", rd, 32'h0);
        wb(1'b0, 2'd2, 4'hF, 32'h0, rd);
        check("post_reset_status", rd, status_expect(sw_m, 4'h0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
